// File: rtl/lcd_text_arbiter.sv
// Round-robin arbiter sharing a 32-character LCD text buffer between two writers.
// Define LCD_ARB_TIMEOUT_EN to build the grant watchdog; otherwise grants never time out.
module lcd_text_arbiter #(
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_i,
    input  logic [1:0]   clr_req_i,
    input  logic [1:0]   done_i,
    input  logic [1:0]   wr_en_i,
    input  logic [4:0]   wr_addr0_i,
    input  logic [4:0]   wr_addr1_i,
    input  logic [7:0]   wr_char0_i,
    input  logic [7:0]   wr_char1_i,
    output logic [1:0]   gnt_o,
    output logic         busy_o,
    output logic         update_o,
    output logic         timeout_o,
    output logic [255:0] disp_text_o
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_GRANT} state_t;

    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    logic            pri_q, pri_d;
    logic [4:0]      clr_idx_q, clr_idx_d;
    logic            update_q, update_d;
    logic [31:0][7:0] buf_q;

    logic            wr_acc;
    logic [4:0]      wr_addr;
    logic [7:0]      wr_char;
    logic            wd_expire;

    assign wr_addr = sel_q ? wr_addr1_i : wr_addr0_i;
    assign wr_char = sel_q ? wr_char1_i : wr_char0_i;
    assign wr_acc  = (state_q == S_GRANT) && wr_en_i[sel_q];

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q;

    // Expiry fires on the cycle the counter sits at its terminal value with no write.
    assign wd_expire = (state_q == S_GRANT) && !wr_acc && (wd_q == WD_LAST);

    always_comb begin
        wd_d = wd_q;
        if (state_q != S_GRANT || wr_acc) begin
            wd_d = '0;
        end else if (wd_q != WD_LAST) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= wd_expire;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        pri_d     = pri_q;
        clr_idx_d = clr_idx_q;
        update_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    sel_d   = (&req_i) ? pri_q : req_i[1];
                    state_d = clr_req_i[sel_d] ? S_CLEAR : S_GRANT;
                end
            end
            S_CLEAR: begin
                // Index wraps back to 0 on the last position, ready for the next clear.
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (done_i[sel_q] || !req_i[sel_q] || wd_expire) begin
                    state_d  = S_IDLE;
                    update_d = 1'b1;
                    pri_d    = ~sel_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            pri_q     <= 1'b0;
            clr_idx_q <= 5'd0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pri_q     <= pri_d;
            clr_idx_q <= clr_idx_d;
            update_q  <= update_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= {32{BLANK_CHAR}};
        end else if (state_q == S_CLEAR) begin
            buf_q[clr_idx_q] <= BLANK_CHAR;
        end else if (wr_acc) begin
            buf_q[wr_addr] <= wr_char;
        end
    end

    assign gnt_o       = (state_q == S_GRANT) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy_o      = (state_q != S_IDLE);
    assign update_o    = update_q;
    assign disp_text_o = buf_q;

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Randomized scoreboard bench for lcd_text_arbiter: session-level reference model,
// monitor pops expected buffer snapshots on every update pulse.
`timescale 1ns/1ps
module tb_lcd_text_arbiter;
    localparam int TMO = 8;
    localparam logic [255:0] ALL_BLANK = {32{8'h20}};

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_i, clr_req_i, done_i, wr_en_i;
    logic [4:0]   wr_addr0_i, wr_addr1_i;
    logic [7:0]   wr_char0_i, wr_char1_i;
    logic [1:0]   gnt_o;
    logic         busy_o, update_o, timeout_o;
    logic [255:0] disp_text_o;

    lcd_text_arbiter #(.TIMEOUT(TMO), .BLANK_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .clr_req_i(clr_req_i),
        .done_i(done_i), .wr_en_i(wr_en_i),
        .wr_addr0_i(wr_addr0_i), .wr_addr1_i(wr_addr1_i),
        .wr_char0_i(wr_char0_i), .wr_char1_i(wr_char1_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .update_o(update_o),
        .timeout_o(timeout_o), .disp_text_o(disp_text_o)
    );

    always #5 clk = ~clk;

    typedef struct { int who; logic [255:0] text; bit to; } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_buf [32];
    int ref_pri;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] ref_text();
        logic [255:0] t;
        for (int i = 0; i < 32; i++) t[8*i +: 8] = ref_buf[i];
        return t;
    endfunction

    task automatic ref_blank();
        for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
    endtask

    // Monitor: compare every update pulse against the oldest expected session record.
    int last_holder = -1;
    bit prev_upd = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            prev_upd    = 1'b0;
            last_holder = -1;
        end else begin
            chk("gnt_onehot0", $onehot0(gnt_o), 1);
            if (update_o) begin
                chk("update_one_cycle", prev_upd, 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_update", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("holder", last_holder, e.who);
                    chk("text_at_update", disp_text_o, e.text);
                    chk("timeout_flag", timeout_o, e.to);
                end
            end else begin
                chk("timeout_quiet", timeout_o, 0);
            end
            if (gnt_o != 2'b00) last_holder = gnt_o[1] ? 1 : 0;
            prev_upd = update_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 0; clr_req_i = 0; done_i = 0; wr_en_i = 0;
        wr_addr0_i = 0; wr_addr1_i = 0; wr_char0_i = 0; wr_char1_i = 0;
    endtask

    task automatic set_wr(input int who, input logic [4:0] a, input logic [7:0] c);
        wr_en_i[who] = 1'b1;
        if (who == 0) begin wr_addr0_i = a; wr_char0_i = c; end
        else begin wr_addr1_i = a; wr_char1_i = c; end
    endtask

    // Request from IDLE and check grant latency (1 cycle, or 33 with a clear).
    task automatic start_session(input int who, input bit clr);
        int t;
        req_i[who] = 1'b1;
        clr_req_i[who] = clr;
        tick();
        t = 1;
        if (clr) begin
            chk("clear_busy", busy_o, 1);
            chk("clear_gnt_low", gnt_o, 0);
        end
        while (gnt_o[who] !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        chk("grant_latency", t, clr ? 33 : 1);
        chk("grant_busy", busy_o, 1);
        if (clr) begin
            ref_blank();
            chk("cleared_text", disp_text_o, ALL_BLANK);
        end
    endtask

    // Random writes with short gaps; the last write is left pending for end_session.
    task automatic do_writes(input int who, input int nw, input bit noise);
        for (int k = 0; k < nw; k++) begin
            logic [4:0] a;
            logic [7:0] c;
            int gap;
            gap = $urandom_range(0, 2);
            wr_en_i = 0;
            repeat (gap) tick();
            a = 5'($urandom);
            c = 8'($urandom);
            set_wr(who, a, c);
            ref_buf[a] = c;
            if (noise && ($urandom_range(0, 1) == 1)) set_wr(1 - who, 5'($urandom), 8'($urandom));
            if (k < nw - 1) tick();
        end
    endtask

    // mode 0: done together with the pending write; mode 1: commit, then drop req.
    task automatic end_session(input int who, input int mode, input bit keep_req);
        exp_t e;
        if (mode == 1) begin
            tick();
            wr_en_i = 0;
            req_i[who] = 1'b0;
        end else begin
            done_i[who] = 1'b1;
        end
        e.who = who; e.text = ref_text(); e.to = 1'b0;
        sbq.push_back(e);
        ref_pri = 1 - who;
        tick();
        chk("gnt_drop", gnt_o, 0);
        chk("busy_drop", busy_o, 0);
        done_i = 0;
        wr_en_i = 0;
        clr_req_i[who] = 1'b0;
        if (!keep_req) req_i[who] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int t, who, cnt;
        exp_t e;
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        ref_blank();
        ref_pri = 0;
        repeat (5) tick();
        chk("reset_text", disp_text_o, ALL_BLANK);
        chk("reset_gnt", gnt_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_update", update_o, 0);

        // Directed: two writes then done.
        start_session(0, 0);
        set_wr(0, 5'd0, 8'h48); ref_buf[0] = 8'h48;
        tick();
        set_wr(0, 5'd16, 8'h49); ref_buf[16] = 8'h49;
        end_session(0, 0, 0);
        chk("byte0", disp_text_o[7:0], 8'h48);
        chk("byte16", disp_text_o[135:128], 8'h49);
        tick();

        // Random single-requester sessions.
        for (int s = 0; s < 8; s++) begin
            who = $urandom_range(0, 1);
            start_session(who, ($urandom_range(0, 3) == 0));
            do_writes(who, $urandom_range(1, 12), 1);
            end_session(who, $urandom_range(0, 1), 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Preload with 'A', then a clearing session from requester 1.
        start_session(0, 0);
        for (int i = 0; i < 32; i++) begin
            set_wr(0, 5'(i), 8'h41);
            ref_buf[i] = 8'h41;
            if (i < 31) tick();
        end
        end_session(0, 0, 0);
        chk("preload_text", disp_text_o, {32{8'h41}});
        start_session(1, 1);
        do_writes(1, 2, 0);
        end_session(1, 0, 0);

        // Both requesting continuously: strict alternation.
        req_i = 2'b11;
        for (int s = 0; s < 4; s++) begin
            t = 0;
            do begin tick(); t++; end while (gnt_o == 2'b00 && t < 5);
            chk("alt_gnt_arrives", (gnt_o != 2'b00), 1);
            who = gnt_o[1] ? 1 : 0;
            chk("alt_order", who, ref_pri);
            do_writes(who, 3, 1);
            end_session(who, 0, 1);
        end
        req_i = 2'b00;
        tick();

        // Idle grant to requester 0.
        start_session(0, 0);
`ifdef LCD_ARB_TIMEOUT_EN
        e.who = 0; e.text = ref_text(); e.to = 1'b1;
        sbq.push_back(e);
        cnt = 0;
        while (gnt_o[0] === 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("watchdog_grant_cycles", cnt, TMO);
        ref_pri = 1;
        req_i = 2'b11;
        tick();
        chk("pri_after_timeout", gnt_o, 2'b10);
        req_i[0] = 1'b0;
        do_writes(1, 1, 0);
        end_session(1, 0, 0);
`else
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gnt_o[0] === 1'b1) cnt++;
        end
        chk("grant_held_100", cnt, 100);
        end_session(0, 1, 0);
`endif
        tick();

        // Reset in the middle of a grant: no update, buffer blanked, pri back to 0.
        start_session(1, 0);
        do_writes(1, 3, 0);
        tick();
        wr_en_i = 0;
        reset = 1'b1;
        tick();
        chk("midreset_gnt", gnt_o, 0);
        chk("midreset_busy", busy_o, 0);
        chk("midreset_update", update_o, 0);
        chk("midreset_text", disp_text_o, ALL_BLANK);
        reset = 1'b0;
        idle_inputs();
        ref_blank();
        ref_pri = 0;
        tick();
        req_i = 2'b11;
        tick();
        chk("pri_after_reset", gnt_o, 2'b01);
        req_i[1] = 1'b0;
        do_writes(0, 2, 1);
        end_session(0, 0, 0);

        repeat (4) tick();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
